// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : ULX3S push-button board constants shared by the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    localparam int                 BTN_COUNT           = 7;
    localparam logic [BTN_COUNT-1:0] BTN_ACTIVE_LOW_MASK = 7'b0000001;
    localparam int                 CLK_HZ              = 25_000_000;

    // 10 ms of settling and 1 s of hold at the board clock.
    localparam int                 DEBOUNCE_10MS       = CLK_HZ / 100;
    localparam int                 LONGPRESS_1S        = CLK_HZ;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ch
// Description : One button channel: synchroniser, debounce, hold timer, pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int LONGPRESS_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONGPRESS_CYCLES + 1);

    localparam logic [DEB_W-1:0]  c_deb_last = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(LONGPRESS_CYCLES);
    localparam logic [HOLD_W-1:0] c_hold_pre = HOLD_W'(LONGPRESS_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("btn_debounce_ch: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONGPRESS_CYCLES < 1) begin : g_chk_long
        $error("btn_debounce_ch: LONGPRESS_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_deb_cnt;
    logic [HOLD_W-1:0]      r_hold;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_long;

    logic w_s;
    logic w_settled;
    logic w_level_nxt;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_settled   = (w_s != r_level) && (r_deb_cnt == c_deb_last);
    assign w_level_nxt = r_level ^ w_settled;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= '0;
            r_deb_cnt <= '0;
            r_hold    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};

            if ((w_s == r_level) || w_settled) begin
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end

            r_level   <= w_level_nxt;
            r_press   <= w_settled & ~r_level;
            r_release <= w_settled & r_level;

            // The press edge itself counts as hold cycle 1.
            if (!w_level_nxt) begin
                r_hold <= '0;
            end else if (r_hold != c_hold_max) begin
                r_hold <= r_hold + HOLD_W'(1);
            end

            r_long <= w_level_nxt && (r_hold == c_hold_pre);
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Polarity-normalising debouncer for the ULX3S push-buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import btn_pkg::*;
#(
    parameter int                   NUM_BTN          = BTN_COUNT,
    parameter int                   SYNC_STAGES      = 2,
    parameter int                   DEBOUNCE_CYCLES  = DEBOUNCE_10MS,
    parameter int                   LONGPRESS_CYCLES = LONGPRESS_1S,
    parameter logic [NUM_BTN-1:0]   ACTIVE_LOW_MASK  = BTN_ACTIVE_LOW_MASK
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long
);

    logic [NUM_BTN-1:0] w_norm;

    // Flip active-low pins so every channel sees 1 = pressed.
    assign w_norm = i_btn ^ ACTIVE_LOW_MASK;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES      (SYNC_STAGES),
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONGPRESS_CYCLES (LONGPRESS_CYCLES)
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_btn_n   (w_norm[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_long    (o_long[g])
        );
    end

endmodule : btn_debounce
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce
// Description : Directed + random bench for btn_debounce with a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

    localparam int NUM  = 7;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 16;
    localparam int HLEN = SYNC + DEB;
    localparam int LAT  = SYNC + DEB;

    logic           clk = 1'b0;
    logic           rst;
    logic [NUM-1:0] btn;
    logic [NUM-1:0] lvl, prs, rls, lng;
    logic [NUM-1:0] mask_v;

    btn_debounce #(
        .NUM_BTN          (NUM),
        .SYNC_STAGES      (SYNC),
        .DEBOUNCE_CYCLES  (DEB),
        .LONGPRESS_CYCLES (LONG),
        .ACTIVE_LOW_MASK  (7'b0000001)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_btn     (btn),
        .o_level   (lvl),
        .o_press   (prs),
        .o_release (rls),
        .o_long    (lng)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: a change is accepted once the last DEB synchronised samples all disagree.
    bit             hist [NUM][HLEN];
    bit             m_level [NUM];
    int             m_hold [NUM];
    logic [NUM-1:0] e_level, e_press, e_rel, e_long;

    int press_cnt [NUM];
    int rel_cnt   [NUM];
    int long_cnt  [NUM];
    int last_press[NUM];
    int last_rel  [NUM];
    int last_long [NUM];

    task automatic model_edge();
        for (int ch = 0; ch < NUM; ch++) begin
            bit nv;
            bit diff;
            nv = btn[ch] ^ mask_v[ch];
            e_press[ch] = 1'b0;
            e_rel[ch]   = 1'b0;
            e_long[ch]  = 1'b0;
            if (rst) begin
                for (int k = 0; k < HLEN; k++) hist[ch][k] = 1'b0;
                m_level[ch] = 1'b0;
                m_hold[ch]  = 0;
            end else begin
                for (int k = HLEN - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = nv;
                diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (hist[ch][SYNC+j] == m_level[ch]) diff = 1'b0;
                if (diff) begin
                    e_press[ch] = !m_level[ch];
                    e_rel[ch]   = m_level[ch];
                    m_level[ch] = !m_level[ch];
                end
                if (m_level[ch]) begin
                    if (m_hold[ch] < LONG) begin
                        m_hold[ch]++;
                        if (m_hold[ch] == LONG) e_long[ch] = 1'b1;
                    end
                end else begin
                    m_hold[ch] = 0;
                end
            end
            e_level[ch] = m_level[ch];
        end
    endtask

    task automatic check_vec(input string tag, input logic [NUM-1:0] act, input logic [NUM-1:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string tag, input int act, input int exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic clr();
        for (int ch = 0; ch < NUM; ch++) begin
            press_cnt[ch] = 0; rel_cnt[ch] = 0; long_cnt[ch] = 0;
            last_press[ch] = -1; last_rel[ch] = -1; last_long[ch] = -1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            model_edge();
            #1;
            check_vec("level",   lvl, e_level);
            check_vec("press",   prs, e_press);
            check_vec("release", rls, e_rel);
            check_vec("long",    lng, e_long);
            for (int ch = 0; ch < NUM; ch++) begin
                if (prs[ch]) begin press_cnt[ch]++; last_press[ch] = cyc; end
                if (rls[ch]) begin rel_cnt[ch]++;   last_rel[ch]   = cyc; end
                if (lng[ch]) begin long_cnt[ch]++;  last_long[ch]  = cyc; end
            end
        end
    endtask

    initial begin
        int c0;
        int p;
        int tot;
        mask_v = 7'b0000001;
        clr();

        // Reset with every button released, then idle.
        rst = 1'b1;
        btn = 7'b0000001;
        step(3);
        check_vec("reset_level", lvl, 7'b0000000);
        rst = 1'b0;
        step(50);
        tot = 0;
        for (int ch = 0; ch < NUM; ch++) tot += press_cnt[ch] + rel_cnt[ch] + long_cnt[ch];
        check_int("idle_events", tot, 0);

        // Clean step on channel 2.
        clr();
        btn[2] = 1'b1; c0 = cyc;
        step(10);
        check_int("ch2_press_cyc", last_press[2], c0 + LAT);
        check_int("ch2_press_cnt", press_cnt[2], 1);
        btn[2] = 1'b0; c0 = cyc;
        step(10);
        check_int("ch2_rel_cyc", last_rel[2], c0 + LAT);

        // Bounce on channel 3.
        clr();
        btn[3] = 1'b1; step(2);
        btn[3] = 1'b0; step(2);
        btn[3] = 1'b1; step(2);
        btn[3] = 1'b0; step(2);
        btn[3] = 1'b1; c0 = cyc;
        step(10);
        check_int("ch3_press_cnt", press_cnt[3], 1);
        check_int("ch3_press_cyc", last_press[3], c0 + LAT);
        btn[3] = 1'b0;
        step(10);

        // Active-low channel 0.
        clr();
        btn[0] = 1'b0; c0 = cyc;
        step(10);
        check_int("ch0_press_cyc", last_press[0], c0 + LAT);
        check_vec("ch0_level_only", lvl, 7'b0000001);
        btn[0] = 1'b1;
        step(10);

        // Long press on channel 4, then a short press with no long event.
        clr();
        btn[4] = 1'b1;
        step(LAT);
        p = last_press[4];
        step(30);
        check_int("ch4_long_cnt", long_cnt[4], 1);
        check_int("ch4_long_cyc", last_long[4], p + LONG - 1);
        btn[4] = 1'b0;
        step(10);
        clr();
        btn[4] = 1'b1;
        step(LAT + 4);
        btn[4] = 1'b0;
        step(12);
        check_int("ch4_short_press", press_cnt[4], 1);
        check_int("ch4_short_long", long_cnt[4], 0);

        // Simultaneous press, reset mid-hold, re-press with pins held.
        clr();
        btn[1] = 1'b1; btn[5] = 1'b1; c0 = cyc;
        step(10);
        check_int("ch1_press_cyc", last_press[1], c0 + LAT);
        check_int("ch5_press_cyc", last_press[5], c0 + LAT);
        rst = 1'b1;
        step(1);
        check_vec("mid_reset_level", lvl, 7'b0000000);
        rst = 1'b0; c0 = cyc;
        clr();
        step(10);
        check_int("no_release", rel_cnt[1] + rel_cnt[5], 0);
        check_int("ch1_repress", last_press[1], c0 + LAT);
        check_int("ch5_repress", last_press[5], c0 + LAT);
        btn[1] = 1'b0; btn[5] = 1'b0;
        step(10);

        // Random bouncing on all channels with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < NUM; ch++)
                if ($urandom_range(0, 11) == 0) btn[ch] = ~btn[ch];
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 1'b0;
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_btn_debounce
`default_nettype wire
